// File: rtl/fc_layer.sv
// rtl/fc_layer.sv - fully connected layer streaming flatten memory against a weight ROM
// One MAC per cycle through operand, product and accumulate/emit stages behind a read-sequencing FSM.
module fc_layer #(
  parameter int N_IN  = 2048,
  parameter int N_OUT = 10,
  parameter int RELU  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  output logic        busy,
  output logic        crd,
  output logic [2:0]  csel,
  output logic [11:0] caddr_rd,
  input  logic [19:0] cdata_rd,
  output logic [14:0] waddr,
  input  logic [19:0] wdata,
  output logic        ovalid,
  output logic [3:0]  oaddr,
  output logic [19:0] odata
);
  localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state;
  logic [IW-1:0]      i_cnt;
  logic [KW-1:0]      k_cnt;
  logic               last_i;
  logic               last_k;
  logic               final_term;

  logic               v1, first1, end1;
  logic [KW-1:0]      k1;
  logic signed [19:0] d1, w1;
  logic               v2, first2, end2;
  logic [KW-1:0]      k2;
  logic signed [39:0] d_ext, w_ext;
  logic signed [39:0] prod;
  logic signed [50:0] acc, acc_next, rounded;
  logic               ovf;
  logic [19:0]        sat, result;

  assign last_i     = (i_cnt == IW'(N_IN - 1));
  assign last_k     = (k_cnt == KW'(N_OUT - 1));
  assign caddr_rd   = 12'(i_cnt);
  assign final_term = v2 && end2 && (k2 == KW'(N_OUT - 1));

  // Rounded value is pre-shifted to 4.16 so the range test sees every upper bit.
  always_comb begin
    d_ext    = {{20{d1[19]}}, d1};
    w_ext    = {{20{w1[19]}}, w1};
    acc_next = first2 ? {{11{prod[39]}}, prod} : acc + {{11{prod[39]}}, prod};
    rounded  = (acc_next + 51'sd32768) >>> 16;
    ovf      = !((&rounded[50:19]) || !(|rounded[50:19]));
    sat      = ovf ? (rounded[50] ? 20'h80000 : 20'h7FFFF) : rounded[19:0];
    result   = ((RELU != 0) && sat[19]) ? 20'h00000 : sat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      crd   <= 1'b0;
      csel  <= 3'b000;
      i_cnt <= '0;
      k_cnt <= '0;
      waddr <= '0;
    end else begin
      case (state)
        IDLE: if (ready) begin
          state <= RUN;
          busy  <= 1'b1;
          crd   <= 1'b1;
          csel  <= 3'b101;
          i_cnt <= '0;
          k_cnt <= '0;
          waddr <= '0;
        end
        RUN: if (last_i && last_k) begin
          state <= DRAIN;
          crd   <= 1'b0;
          csel  <= 3'b000;
          i_cnt <= '0;
          k_cnt <= '0;
          waddr <= '0;
        end else begin
          // Weight rows are contiguous, so k*N_IN+i is a plain running count.
          waddr <= waddr + 15'd1;
          if (last_i) begin
            i_cnt <= '0;
            k_cnt <= k_cnt + KW'(1);
          end else begin
            i_cnt <= i_cnt + IW'(1);
          end
        end
        DRAIN: if (final_term) state <= DONE;
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1     <= 1'b0;
      first1 <= 1'b0;
      end1   <= 1'b0;
      k1     <= '0;
      d1     <= '0;
      w1     <= '0;
      v2     <= 1'b0;
      first2 <= 1'b0;
      end2   <= 1'b0;
      k2     <= '0;
      prod   <= '0;
      acc    <= '0;
      ovalid <= 1'b0;
      oaddr  <= '0;
      odata  <= '0;
    end else begin
      v1     <= crd;
      first1 <= (i_cnt == '0);
      end1   <= last_i;
      k1     <= k_cnt;
      d1     <= cdata_rd;
      w1     <= wdata;
      v2     <= v1;
      first2 <= first1;
      end2   <= end1;
      k2     <= k1;
      prod   <= d_ext * w_ext;
      if (v2) acc <= acc_next;
      ovalid <= v2 && end2;
      if (v2 && end2) begin
        oaddr <= 4'(k2);
        odata <= result;
      end
    end
  end
endmodule

// File: tb/tb_fc_layer.sv
// tb/tb_fc_layer.sv - directed and randomized checks of fc_layer against an arithmetic reference
// Two instances (RELU=1 and RELU=0) share stimulus and a combinational memory model.
module tb_fc_layer;
  localparam int N_IN  = 32;
  localparam int N_OUT = 10;
  localparam int IW    = $clog2(N_IN);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ready = 1'b0;

  logic        busy1, crd1, ov1, busy0, crd0, ov0;
  logic [2:0]  csel1, csel0;
  logic [11:0] caddr1, caddr0;
  logic [14:0] waddr1, waddr0;
  logic [19:0] cdata1, wdata1, cdata0, wdata0;
  logic [3:0]  oaddr1, oaddr0;
  logic [19:0] odata1, odata0;

  logic signed [19:0] dmem [N_IN];
  logic signed [19:0] wmem [N_IN*N_OUT];
  logic [19:0] exp_relu [N_OUT];
  logic [19:0] exp_lin  [N_OUT];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always_comb begin
    cdata1 = dmem[caddr1[IW-1:0]];
    cdata0 = dmem[caddr0[IW-1:0]];
    wdata1 = (int'(waddr1) < N_IN*N_OUT) ? wmem[int'(waddr1)] : 20'h0;
    wdata0 = (int'(waddr0) < N_IN*N_OUT) ? wmem[int'(waddr0)] : 20'h0;
  end

  fc_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .RELU(1)) dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy1), .crd(crd1), .csel(csel1),
    .caddr_rd(caddr1), .cdata_rd(cdata1), .waddr(waddr1), .wdata(wdata1),
    .ovalid(ov1), .oaddr(oaddr1), .odata(odata1));

  fc_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .RELU(0)) dut_lin (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy0), .crd(crd0), .csel(csel0),
    .caddr_rd(caddr0), .cdata_rd(cdata0), .waddr(waddr0), .wdata(wdata0),
    .ovalid(ov0), .oaddr(oaddr0), .odata(odata0));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic build_expected();
    for (int k = 0; k < N_OUT; k++) begin
      longint sum = 0;
      longint r;
      for (int i = 0; i < N_IN; i++) sum += longint'(dmem[i]) * longint'(wmem[k*N_IN+i]);
      r = (sum + 32768) >>> 16;
      if (r > 524287) r = 524287;
      else if (r < -524288) r = -524288;
      exp_lin[k]  = r[19:0];
      exp_relu[k] = (r < 0) ? 20'h00000 : r[19:0];
    end
  endtask

  task automatic fill_const(input logic [19:0] dv, input logic [19:0] wv);
    foreach (dmem[i]) dmem[i] = dv;
    foreach (wmem[i]) wmem[i] = wv;
  endtask

  task automatic fill_random(input int drange, input int wrange);
    foreach (dmem[i]) begin
      int v = int'($urandom_range(0, 2*drange - 1)) - drange;
      dmem[i] = v[19:0];
    end
    foreach (wmem[i]) begin
      int v = int'($urandom_range(0, 2*wrange - 1)) - wrange;
      wmem[i] = v[19:0];
    end
  endtask

  task automatic run_layer(input string tag, input bit hold_ready);
    int c = 0;
    int np = 0;
    int seq_err = 0;
    int pair_err = 0;
    int hold_err = 0;
    logic [19:0] held1 = '0;
    logic [19:0] held0 = '0;
    build_expected();
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    if (!hold_ready) ready = 1'b0;
    check({tag, "_first_caddr"}, 32'(caddr1), 32'd0);
    check({tag, "_first_waddr"}, 32'(waddr1), 32'd0);
    while (np < N_OUT && c < N_OUT*N_IN + 20) begin
      if (c < N_OUT*N_IN) begin
        if (crd1 !== 1'b1 || csel1 !== 3'b101 || caddr1 !== 12'(c % N_IN) || waddr1 !== 15'(c))
          seq_err++;
      end else if (crd1 !== 1'b0 || csel1 !== 3'b000) begin
        seq_err++;
      end
      if (busy1 !== 1'b1) seq_err++;
      if (ov0 !== ov1 || busy0 !== busy1 || crd0 !== crd1 || caddr0 !== caddr1 || waddr0 !== waddr1)
        pair_err++;
      if (ov1 === 1'b1) begin
        check({tag, "_oaddr"}, 32'(oaddr1), 32'(np));
        check({tag, "_odata_relu"}, 32'(odata1), 32'(exp_relu[np]));
        check({tag, "_odata_lin"}, 32'(odata0), 32'(exp_lin[np]));
        check({tag, "_latency"}, 32'(c), 32'(np*N_IN + N_IN - 1 + 3));
        held1 = odata1;
        held0 = odata0;
        np++;
      end else if (np > 0 && (odata1 !== held1 || odata0 !== held0)) begin
        hold_err++;
      end
      if (np < N_OUT) begin
        @(negedge clk);
        c++;
      end
    end
    check({tag, "_pulse_count"}, 32'(np), 32'(N_OUT));
    check({tag, "_busy_at_last"}, 32'(busy1), 32'd1);
    @(negedge clk);
    check({tag, "_busy_after"}, 32'({busy1, busy0, ov1}), 32'd0);
    check({tag, "_addr_seq"}, 32'(seq_err), 32'd0);
    check({tag, "_pair"}, 32'(pair_err), 32'd0);
    check({tag, "_hold"}, 32'(hold_err), 32'd0);
  endtask

  initial begin
    int ov_seen;
    fill_const(20'h0, 20'h0);
    // Reset held with ready high: nothing may start.
    reset = 1'b0;
    ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'({busy1, busy0}), 32'd0);
    check("rst_crd_csel", 32'({crd1, crd0, csel1, csel0}), 32'd0);
    check("rst_caddr", 32'({caddr1, caddr0}), 32'd0);
    check("rst_waddr", 32'({waddr1, waddr0}), 32'd0);
    check("rst_ovalid_oaddr", 32'({ov1, ov0, oaddr1, oaddr0}), 32'd0);
    check("rst_odata1", 32'(odata1), 32'd0);
    check("rst_odata0", 32'(odata0), 32'd0);
    ready = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_hold", 32'({busy1, crd1, ov1}), 32'd0);

    fill_const(20'h10000, 20'h10000);
    run_layer("pos_sat", 1'b0);

    fill_const(20'h0, 20'h08000);
    dmem[0] = 20'h10000;
    run_layer("single", 1'b0);

    fill_const(20'h0, 20'h0);
    dmem[5] = 20'h00001;
    for (int k = 0; k < N_OUT; k++) wmem[k*N_IN+5] = 20'h08000;
    run_layer("round_up", 1'b0);
    for (int k = 0; k < N_OUT; k++) wmem[k*N_IN+5] = 20'h07FFF;
    run_layer("round_dn", 1'b0);

    fill_const(20'h10000, 20'hF0000);
    run_layer("neg_sat", 1'b0);

    fill_random(65536, 16384);
    run_layer("rand_mid", 1'b0);
    fill_random(524288, 524288);
    run_layer("rand_full", 1'b0);

    // Abort in the last read of neuron 3, while its result is still in the pipeline.
    fill_random(65536, 8192);
    @(negedge clk);
    ready = 1'b1;
    repeat (4*N_IN) @(negedge clk);
    check("mid_in_k3", 32'(waddr1), 32'(4*N_IN - 1));
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'({busy1, busy0}), 32'd0);
    check("mid_rst_crd", 32'({crd1, crd0, ov1, ov0}), 32'd0);
    ov_seen = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (ov1 === 1'b1 || ov0 === 1'b1) ov_seen++;
    end
    ready = 1'b0;
    reset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (ov1 === 1'b1 || ov0 === 1'b1 || busy1 === 1'b1) ov_seen++;
    end
    check("mid_no_ovalid", 32'(ov_seen), 32'd0);
    run_layer("post_rst", 1'b1);

    // ready still high after DONE: a fresh run starts from the first address.
    @(negedge clk);
    check("restart_busy", 32'({busy1, crd1}), 32'd3);
    check("restart_addr", 32'({caddr1, waddr1}), 32'd0);
    ready = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fc_layer.md
FC_LAYER -- requirements
Module: fc_layer

Interface
REQ-001 SHALL provide parameters: N_IN, default 2048, the flattened input vector length; N_OUT, default 10, the number of output neurons; RELU, default 1, which enables ReLU on outputs when 1.
REQ-002 SHALL provide port clk, input, 1 bit: single clock; all logic rising-edge triggered.
REQ-003 SHALL provide port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL provide port ready, input, 1 bit: start request, sampled only in IDLE.
REQ-005 SHALL provide port busy, output, 1 bit: high from accepted start until the final result is emitted.
REQ-006 SHALL provide port crd, output, 1 bit: read strobe to the layer-2 flatten memory.
REQ-007 SHALL provide port csel, output, 3 bits: memory select; 3'b101 whenever crd=1, else 3'b000.
REQ-008 SHALL provide port caddr_rd, output, 12 bits: flatten-memory read address.
REQ-009 SHALL provide port cdata_rd, input, 20 bits: signed 4.16 data, valid at the rising edge after crd/caddr_rd are presented.
REQ-010 SHALL provide port waddr, output, 15 bits: weight ROM address, equal to k*N_IN+i.
REQ-011 SHALL provide port wdata, input, 20 bits: signed 4.16 weight, valid at the rising edge after waddr is presented.
REQ-012 SHALL provide port ovalid, output, 1 bit: one-cycle pulse per neuron result.
REQ-013 SHALL provide port oaddr, output, 4 bits: neuron index k of the current result.
REQ-014 SHALL provide port odata, output, 20 bits: signed 4.16 neuron result.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-016 SHALL transition IDLE->RUN on the edge where ready=1; busy=1 from the next cycle.
REQ-017 SHALL, in RUN, assert crd=1 every cycle, with caddr_rd=i and waddr=k*N_IN+i, i=0..N_IN-1 for k=0..N_OUT-1, with no gap between neurons.
REQ-018 SHALL transition RUN->DRAIN after the read for (k=N_OUT-1, i=N_IN-1); crd=0 in DRAIN.
REQ-019 SHALL implement the pipeline as: read data and weight sampled at t+1, 40-bit signed product registered at t+2, accumulated at t+3.
REQ-020 SHALL sustain a throughput of one MAC per cycle.
REQ-021 SHALL hold the accumulator in 51-bit signed form.
REQ-022 SHALL clear the accumulator for neuron k by loading its i=0 product rather than adding to the prior sum, so there are no bubbles between neurons.
REQ-023 SHALL pulse ovalid, with oaddr=k, 3 cycles after the i=N_IN-1 read of neuron k.
REQ-024 SHALL compute odata from acc + 2^15 (round half up), taking bits [35:16].
REQ-025 SHALL saturate odata to 0x7FFFF / 0x80000 when acc exceeds the signed 20-bit range at 4.16 scale.
REQ-026 SHALL force negative results to 0x00000 when RELU=1, applied after saturation.
REQ-027 SHALL hold odata and oaddr stable until the next ovalid.
REQ-028 SHALL transition DRAIN->DONE on the final ovalid.
REQ-029 SHALL transition DONE->IDLE on the next cycle with busy=0; busy falls exactly one cycle after the final ovalid.
REQ-030 SHALL ignore ready while busy=1.
REQ-031 SHALL, when ready is still 1 in IDLE after DONE, start a new run from i=0, k=0.
REQ-032 SHALL treat caddr_rd bits above log2(N_IN) as zero.

Reset
REQ-033 SHALL, while reset=0, asynchronously force state=IDLE, busy=0, crd=0, csel=0, caddr_rd=0, waddr=0, ovalid=0, oaddr=0, odata=0, and clear the accumulator and pipeline registers.
REQ-034 SHALL abort an in-progress run on reset mid-operation, emit no further ovalid, and start the next run from k=0, i=0.
REQ-035 SHALL leave the block in IDLE on reset release and require ready=1 to start.

Verification
REQ-036 SHALL verify reset: hold reset=0 with ready=1 -> all outputs 0, no crd, state IDLE.
REQ-037 SHALL verify positive saturation: all data 0x10000 and all weights 0x10000 (N_IN=2048) -> ten ovalid pulses, odata=0x7FFFF, oaddr 0..9, busy low one cycle after the 10th pulse.
REQ-038 SHALL verify a single term: data[0]=0x10000, others 0, all weights 0x08000 -> odata=0x08000 for every k.
REQ-039 SHALL verify rounding: data[5]=0x00001, weight(k,5)=0x08000, others 0 -> odata=0x00001; with weight 0x07FFF -> odata=0x00000.
REQ-040 SHALL verify ReLU and negative saturation: data all 0x10000, weights all 0xF0000 (-1.0) -> odata=0x00000 with RELU=1, and 0x80000 with RELU=0.
REQ-041 SHALL verify reset mid-run: pull reset low during k=3 -> busy=0 immediately, no ovalid; then release and assert ready -> first caddr_rd=0, waddr=0, with a full correct 10-result run.
